// File: rtl/set_job_sched_pkg.sv
// set_pkg: shared states, mode codes, operand widths and the queued job record.
package set_pkg;
  localparam int CENT_W = 24;
  localparam int RAD_W = 12;
  localparam int CAND_W = 8;
  localparam logic [1:0] MODE_A = 2'd0;
  localparam logic [1:0] MODE_AND = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;
  localparam logic [1:0] MODE_ILL = 2'd3;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, RECOVER} state_t;
  typedef struct packed {
    logic [CENT_W-1:0] central;
    logic [RAD_W-1:0] radius;
    logic [1:0] mode;
  } job_t;
endpackage

// File: rtl/set_job_sched_rr_arb2.sv
// set_rr_arb2: two-way round-robin grant; rr_last remembers the last winner.
module set_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant,
  output logic       grant_valid
);
  logic rr_last_q, rr_last_d;
  always_comb begin
    grant_valid = |req;
    grant = &req ? ~rr_last_q : req[1];
    rr_last_d = (take && grant_valid) ? grant : rr_last_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_last_q <= 1'b1;
    else rr_last_q <= rr_last_d;
endmodule

// File: rtl/set_job_sched.sv
// set_job_sched: queues one job per requester, runs the SET engine, and routes
// the count (or an error) back to the owner; a watchdog recovers a hung engine.
module set_job_sched
  import set_pkg::*;
#(
  parameter int TO_W = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CENT_W-1:0] req0_central,
  input  logic [RAD_W-1:0]  req0_radius,
  input  logic [1:0]        req0_mode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CENT_W-1:0] req1_central,
  input  logic [RAD_W-1:0]  req1_radius,
  input  logic [1:0]        req1_mode,
  output logic              rsp0_valid,
  output logic [CAND_W-1:0] rsp0_candidate,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [CAND_W-1:0] rsp1_candidate,
  output logic              rsp1_err,
  output logic              set_en,
  output logic [CENT_W-1:0] set_central,
  output logic [RAD_W-1:0]  set_radius,
  output logic [1:0]        set_mode,
  output logic              eng_rst,
  input  logic              set_busy,
  input  logic              set_valid,
  input  logic [CAND_W-1:0] set_candidate
);
  state_t state_q, state_d;
  job_t [1:0] slot_q, slot_d;
  logic [1:0] full_q, full_d;
  job_t cur_q, cur_d;
  logic owner_q, owner_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [1:0][CAND_W-1:0] rsp_cand_q, rsp_cand_d;
  logic [1:0] rsp_err_q, rsp_err_d;
  logic grant, grant_valid, take;
  set_rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .req(full_q),
    .take(take),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    full_d = full_q;
    cur_d = cur_q;
    owner_d = owner_q;
    wd_d = wd_q;
    rsp_cand_d = rsp_cand_q;
    rsp_err_d = rsp_err_q;
    take = 1'b0;
    set_en = 1'b0;
    if (req0_valid && !full_q[0]) begin
      full_d[0] = 1'b1;
      slot_d[0] = '{req0_central, req0_radius, req0_mode};
    end
    if (req1_valid && !full_q[1]) begin
      full_d[1] = 1'b1;
      slot_d[1] = '{req1_central, req1_radius, req1_mode};
    end
    case (state_q)
      IDLE: if (grant_valid) begin
        take = 1'b1;
        owner_d = grant;
        cur_d = slot_q[grant];
        state_d = slot_q[grant].mode == MODE_ILL ? RESP : LAUNCH;
        if (slot_q[grant].mode == MODE_ILL) begin
          rsp_cand_d[grant] = '0;
          rsp_err_d[grant] = 1'b1;
        end
      end
      LAUNCH: if (!set_busy) begin
        set_en = 1'b1;
        wd_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + TO_W'(1);
        // a result arriving on the timeout cycle still counts as success
        if (set_valid) begin
          state_d = RESP;
          rsp_cand_d[owner_q] = set_candidate;
          rsp_err_d[owner_q] = 1'b0;
        end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
          state_d = RECOVER;
          rsp_cand_d[owner_q] = '0;
          rsp_err_d[owner_q] = 1'b1;
        end
      end
      RESP, RECOVER: begin
        full_d[owner_q] = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      slot_q <= '0;
      full_q <= '0;
      cur_q <= '0;
      owner_q <= 1'b0;
      wd_q <= '0;
      rsp_cand_q <= '0;
      rsp_err_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      full_q <= full_d;
      cur_q <= cur_d;
      owner_q <= owner_d;
      wd_q <= wd_d;
      rsp_cand_q <= rsp_cand_d;
      rsp_err_q <= rsp_err_d;
    end
  logic done;
  assign done = state_q == RESP || state_q == RECOVER;
  assign req0_ready = ~full_q[0];
  assign req1_ready = ~full_q[1];
  assign rsp0_valid = done && !owner_q;
  assign rsp1_valid = done && owner_q;
  assign rsp0_candidate = rsp_cand_q[0];
  assign rsp1_candidate = rsp_cand_q[1];
  assign rsp0_err = rsp_err_q[0];
  assign rsp1_err = rsp_err_q[1];
  assign eng_rst = state_q == RECOVER;
  assign set_central = cur_q.central;
  assign set_radius = cur_q.radius;
  assign set_mode = cur_q.mode;
endmodule

// File: tb/tb_set_job_sched.sv
// tb_set_job_sched: directed table plus hand-written sequences around a scripted engine.
module tb_set_job_sched;
  localparam int TIMEOUT = 1000;
  logic clk = 1'b0, rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [23:0] req0_central, req1_central, set_central;
  logic [11:0] req0_radius, req1_radius, set_radius;
  logic [1:0] req0_mode, req1_mode, set_mode;
  logic rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_candidate, rsp1_candidate, set_candidate;
  logic set_en, eng_rst, set_busy, set_valid;
  int tests = 0, fails = 0;
  logic [7:0] last_cand [2];
  logic last_err [2];

  always #5 clk = ~clk;

  set_job_sched #(.TO_W(10), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_central(req0_central),
    .req0_radius(req0_radius), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_central(req1_central),
    .req1_radius(req1_radius), .req1_mode(req1_mode),
    .rsp0_valid(rsp0_valid), .rsp0_candidate(rsp0_candidate), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_candidate(rsp1_candidate), .rsp1_err(rsp1_err),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .eng_rst(eng_rst), .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate)
  );

  typedef struct {
    int r;
    logic [23:0] c;
    logic [11:0] rad;
    logic [1:0] m;
    int lat;
    logic [7:0] cand;
    logic [7:0] exp_cand;
    logic exp_err;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic [23:0] c, input logic [11:0] rad, input logic [1:0] m);
    if (r == 0) begin
      req0_valid = 1'b1; req0_central = c; req0_radius = rad; req0_mode = m;
    end else begin
      req1_valid = 1'b1; req1_central = c; req1_radius = rad; req1_mode = m;
    end
  endtask

  task automatic offer(input int r, input logic [23:0] c, input logic [11:0] rad, input logic [1:0] m);
    check("offer_ready", 32'(r ? req1_ready : req0_ready), 1);
    drive(r, c, rad, m);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("ready_low_after_accept", 32'(r ? req1_ready : req0_ready), 0);
  endtask

  task automatic expect_launch(input logic [23:0] c, input logic [11:0] rad, input logic [1:0] m);
    int n;
    n = 0;
    while (!set_en && n < 200) begin
      tick;
      n++;
    end
    check("launch_seen", 32'(set_en), 1);
    check("launch_central", 32'(set_central), 32'(c));
    check("launch_radius", 32'(set_radius), 32'(rad));
    check("launch_mode", 32'(set_mode), 32'(m));
    tick;
    check("en_one_cycle", 32'(set_en), 0);
  endtask

  task automatic engine_reply(input int lat, input logic [7:0] cand, input logic [23:0] c);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (set_en || eng_rst || rsp0_valid || rsp1_valid || set_central !== c) bad = 1'b1;
      tick;
    end
    check("wait_quiet_operands_held", 32'(bad), 0);
    set_valid = 1'b1;
    set_candidate = cand;
    tick;
    set_valid = 1'b0;
    set_candidate = 8'h00;
  endtask

  task automatic wait_rsp(input int r, input logic [7:0] cand, input logic err, input int max, input logic launch_ok);
    int n;
    logic en_seen;
    n = 0;
    en_seen = 1'b0;
    while (!(r ? rsp1_valid : rsp0_valid) && n < max) begin
      en_seen |= set_en;
      tick;
      n++;
    end
    check("rsp_valid", 32'(r ? rsp1_valid : rsp0_valid), 1);
    check("rsp_other_quiet", 32'(r ? rsp0_valid : rsp1_valid), 0);
    check("rsp_candidate", 32'(r ? rsp1_candidate : rsp0_candidate), 32'(cand));
    check("rsp_err", 32'(r ? rsp1_err : rsp0_err), 32'(err));
    check("other_cand_held", 32'(r ? rsp0_candidate : rsp1_candidate), 32'(last_cand[1-r]));
    check("other_err_held", 32'(r ? rsp0_err : rsp1_err), 32'(last_err[1-r]));
    if (!launch_ok) check("no_launch", 32'(en_seen | set_en), 0);
    last_cand[r] = cand;
    last_err[r] = err;
    tick;
    check("rsp_one_cycle", 32'(r ? rsp1_valid : rsp0_valid), 0);
    check("ready_after_rsp", 32'(r ? req1_ready : req0_ready), 1);
  endtask

  task automatic full_job(input int r, input logic [23:0] c, input logic [11:0] rad, input logic [1:0] m, input int lat, input logic [7:0] cand);
    expect_launch(c, rad, m);
    engine_reply(lat, cand, c);
    wait_rsp(r, cand, 1'b0, 1, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic bad;
    tbl[0] = '{0, 24'h440000, 12'h200, 2'd0, 5, 8'd13, 8'd13, 1'b0};
    tbl[1] = '{1, 24'h123400, 12'h560, 2'd1, 3, 8'h42, 8'h42, 1'b0};
    tbl[2] = '{0, 24'hfedc00, 12'hab0, 2'd2, 1, 8'hff, 8'hff, 1'b0};
    tbl[3] = '{1, 24'h777700, 12'h330, 2'd3, 0, 8'h99, 8'h00, 1'b1};
    tbl[4] = '{0, 24'h010200, 12'h120, 2'd3, 0, 8'h55, 8'h00, 1'b1};
    tbl[5] = '{1, 24'h9abc00, 12'h7f0, 2'd0, 10, 8'h07, 8'h07, 1'b0};
    for (int i = 0; i < 2; i++) begin last_cand[i] = 8'h00; last_err[i] = 1'b0; end
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_central = '0; req0_radius = '0; req0_mode = '0;
    req1_central = '0; req1_radius = '0; req1_mode = '0;
    set_busy = 1'b0; set_valid = 1'b0; set_candidate = '0;
    tick; tick;
    check("rst_req0_ready", 32'(req0_ready), 1);
    check("rst_req1_ready", 32'(req1_ready), 1);
    check("rst_set_en", 32'(set_en), 0);
    check("rst_eng_rst", 32'(eng_rst), 0);
    check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
    check("rst_rsp_fields", 32'({rsp0_candidate, rsp0_err, rsp1_candidate, rsp1_err}), 0);
    check("rst_set_ops", 32'({set_central, set_radius, set_mode}), 0);
    rst = 1'b0;
    tick;
    // both slots fill together after reset: requester 0 wins the first tie
    drive(0, 24'h110000, 12'h100, 2'd0);
    drive(1, 24'h220000, 12'h200, 2'd1);
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("pair_both_full", 32'({req0_ready, req1_ready}), 0);
    full_job(0, 24'h110000, 12'h100, 2'd0, 4, 8'h21);
    full_job(1, 24'h220000, 12'h200, 2'd1, 6, 8'h22);
    offer(0, 24'h330000, 12'h300, 2'd2);
    full_job(0, 24'h330000, 12'h300, 2'd2, 2, 8'h23);
    // requester 0 won last, so the next tie goes to requester 1
    drive(0, 24'h440000, 12'h400, 2'd0);
    drive(1, 24'h550000, 12'h500, 2'd2);
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    full_job(1, 24'h550000, 12'h500, 2'd2, 3, 8'h25);
    full_job(0, 24'h440000, 12'h400, 2'd0, 3, 8'h24);
    for (int i = 0; i < 6; i++) begin
      offer(tbl[i].r, tbl[i].c, tbl[i].rad, tbl[i].m);
      if (tbl[i].m == 2'd3) wait_rsp(tbl[i].r, tbl[i].exp_cand, tbl[i].exp_err, 3, 1'b0);
      else begin
        expect_launch(tbl[i].c, tbl[i].rad, tbl[i].m);
        engine_reply(tbl[i].lat, tbl[i].cand, tbl[i].c);
        wait_rsp(tbl[i].r, tbl[i].exp_cand, tbl[i].exp_err, 1, 1'b1);
      end
    end
    // engine busy at grant: launch waits for busy to drop
    set_busy = 1'b1;
    offer(0, 24'hcafe00, 12'hbe0, 2'd1);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bad |= set_en;
      tick;
    end
    check("busy_no_en", 32'(bad), 0);
    check("busy_ops_loaded", 32'(set_central), 32'h00cafe00);
    set_busy = 1'b0;
    #1;
    check("en_when_busy_drops", 32'(set_en), 1);
    full_job(0, 24'hcafe00, 12'hbe0, 2'd1, 20, 8'h3c);
    // hung engine with a queued job behind it
    offer(0, 24'hdead00, 12'h440, 2'd0);
    expect_launch(24'hdead00, 12'h440, 2'd0);
    offer(1, 24'hbeef00, 12'h660, 2'd2);
    bad = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      bad |= eng_rst | rsp0_valid | rsp1_valid | set_en;
      tick;
    end
    check("no_early_recover", 32'(bad), 0);
    check("eng_rst_pulse", 32'(eng_rst), 1);
    wait_rsp(0, 8'h00, 1'b1, 1, 1'b0);
    check("eng_rst_one_cycle", 32'(eng_rst), 0);
    full_job(1, 24'hbeef00, 12'h660, 2'd2, 8, 8'h66);
    // result on the exact timeout cycle is a success
    offer(0, 24'hface00, 12'h880, 2'd1);
    full_job(0, 24'hface00, 12'h880, 2'd1, TIMEOUT - 1, 8'h5a);
    // stray engine valid while idle is ignored
    set_valid = 1'b1; set_candidate = 8'h99;
    tick;
    set_valid = 1'b0; set_candidate = 8'h00;
    check("stray_valid_ignored", 32'({rsp0_valid, rsp1_valid}), 0);
    check("stray_cand_held", 32'(rsp0_candidate), 32'h5a);
    // asynchronous reset in the middle of a run drops the job
    offer(1, 24'h123400, 12'h990, 2'd0);
    expect_launch(24'h123400, 12'h990, 2'd0);
    tick; tick; tick;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'({req0_ready, req1_ready}), 3);
    check("arst_ops", 32'({set_central, set_radius, set_mode}), 0);
    check("arst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_candidate, rsp1_candidate, rsp0_err, rsp1_err}), 0);
    check("arst_en", 32'({set_en, eng_rst}), 0);
    for (int i = 0; i < 2; i++) begin last_cand[i] = 8'h00; last_err[i] = 1'b0; end
    tick;
    rst = 1'b0;
    set_valid = 1'b1; set_candidate = 8'h77;
    tick;
    set_valid = 1'b0; set_candidate = 8'h00;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bad |= rsp0_valid | rsp1_valid | set_en;
      tick;
    end
    check("no_rsp_after_arst", 32'(bad), 0);
    offer(1, 24'h456700, 12'h210, 2'd2);
    full_job(1, 24'h456700, 12'h210, 2'd2, 7, 8'h88);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/set_job_sched.md
Name: set_job_sched

Overview:
- Two-requester scheduler and controller for the single SET candidate-counting engine.
- Queues one job per requester (central, radius, mode) and arbitrates between requesters round-robin.
- Launches the engine with an en pulse and holds its operands stable for the whole run.
- Returns the candidate count, or an error, to the owning requester. A watchdog recovers a hung engine.

Parameters:
- TO_W, 10, width of the watchdog counter.
- TIMEOUT, 1000, max cycles from en to engine valid before recovery. Must be ≥ 600; a nominal run is about 577 cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 offers a job
- req0_ready  out  1  requester 0 slot empty; job accepted on valid&ready
- req0_central  in  24  {xA,yA,xB,yB,8'h00}, 4 bits each
- req0_radius  in  12  {rA,rB,4'h0}
- req0_mode  in  2  0=A, 1=A∧B, 2=A⊕B, 3=illegal
- req1_valid, req1_ready, req1_central, req1_radius, req1_mode  same as requester 0, for requester 1
- rsp0_valid  out  1  one-cycle completion pulse for requester 0
- rsp0_candidate  out  8  result count for requester 0
- rsp0_err  out  1  1 = illegal mode or timeout
- rsp1_valid, rsp1_candidate, rsp1_err  same as requester 0, for requester 1
- set_en  out  1  one-cycle engine start
- set_central  out  24  engine operand
- set_radius  out  12  engine operand
- set_mode  out  2  engine operand
- eng_rst  out  1  one-cycle engine recovery reset (OR'd with rst at top level)
- set_busy  in  1  engine busy
- set_valid  in  1  engine result pulse
- set_candidate  in  8  engine result

Behaviour:
- Reset values:
  - req0_ready and req1_ready = 1.
  - All rsp_*, set_en, eng_rst, set_central, set_radius, set_mode = 0.
  - Slots empty, rr_last = 1 (requester 0 wins the first tie), state IDLE, watchdog counter = 0.
- Slots: one register per requester with a full flag; reqN_ready = ~fullN (registered).
  - A slot is filled on reqN_valid & reqN_ready.
  - A slot is cleared only in RESP or RECOVER, so a new accept into that slot is possible from the following cycle.
- Arbitration (IDLE only):
  - One full slot: that slot is granted.
  - Both full: grant the slot ≠ rr_last.
  - rr_last updates on grant.
- FSM states:
  - IDLE: on grant, load set_* from the granted slot and record the owner.
    - Mode 3 goes to RESP with err=1, candidate=0, and no engine launch.
    - Otherwise go to LAUNCH.
  - LAUNCH: if set_busy=0, assert set_en for exactly one cycle, clear the watchdog, go to WAIT. If set_busy=1, stay with set_en=0.
  - WAIT: the watchdog increments each cycle.
    - set_valid: capture set_candidate, err=0, go to RESP.
    - Watchdog reaches TIMEOUT: go to RECOVER.
    - set_valid and timeout in the same cycle: set_valid wins.
  - RESP: pulse rsp<owner>_valid for one cycle with candidate/err; clear the owner slot; go to IDLE.
  - RECOVER: pulse eng_rst and rsp<owner>_valid with err=1, candidate=0 for one cycle; clear the owner slot; go to IDLE.
- set_central, set_radius and set_mode are held constant from LAUNCH until leaving WAIT, because the engine reads them throughout the run.
- set_valid outside WAIT is ignored.
- rsp_candidate and rsp_err hold their last value between pulses. The non-owner rsp_valid stays 0.
- Latency:
  - Accept to launch: ≥ 2 cycles (fill, IDLE grant, LAUNCH).
  - set_valid to rsp_valid: 1 cycle.
- Reset mid-job: all state is cleared, the job is dropped, and no response is produced.
- A requester may hold req_valid while its slot is full; that job is not accepted until ready=1.

Decomposition:
- Package set_pkg:
  - state enum {IDLE, LAUNCH, WAIT, RESP, RECOVER}
  - mode constants MODE_A=0, MODE_AND=1, MODE_XOR=2, MODE_ILL=3
  - width constants CENT_W=24, RAD_W=12, CAND_W=8
- Sub-module set_rr_arb2: 2-way round-robin grant with rr_last register, plus a grant_valid output.

Test Plan:
- Single job on req0:
  - Stimulus: central=24'h440000, radius=12'h200, mode=0.
  - Response: one set_en pulse; engine model returns 13; rsp0_valid pulse with candidate=13, err=0; req0_ready high again the cycle after RESP.
- Both requesters full in the same cycle after reset:
  - Response: req0 is served first, then req1.
  - Then refill both: req1 is served first (rotation). Responses are routed only to their owner.
- Mode 3 on req1:
  - Response: no set_en; rsp1_valid with err=1, candidate=0 within 3 cycles of accept.
- Engine model holds set_busy=1 for 50 cycles at grant:
  - Response: FSM stays in LAUNCH with set_en=0; set_en fires in the first cycle set_busy=0.
  - set_central is stable until the response.
- Engine model never returns set_valid:
  - Response: after TIMEOUT cycles, eng_rst pulse and rsp0 err=1; the next queued job launches normally.
- Async rst asserted mid-WAIT:
  - Response: all outputs return to reset values immediately; no rsp pulse; a job after reset completes correctly.
  - Also: set_valid coinciding with the timeout cycle gives err=0 with the captured candidate.
